// File: rtl/id_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_pipe: MIPS decode stage (regfile, bypass, BEQ/BNE, load-use       |
// | hazard) with ID/EX pipeline register.                    Revision: 1.0      |
// +----------------------------------------------------------------------------+
module id_stage_pipe #(
  parameter int LENGTH_INSTRUCTION  = 32,
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR      = 11,
  parameter int CANT_BITS_IMMEDIATE = 16,
  parameter int CANT_BITS_EXTENSION = 32,
  localparam int RB = $clog2(CANT_REGISTROS)
) (
  input  logic                           i_clock,
  input  logic                           i_soft_reset,
  input  logic                           i_enable,
  input  logic                           i_valid,
  input  logic [LENGTH_INSTRUCTION-1:0]  i_instruction,
  input  logic [CANT_BITS_ADDR-1:0]      i_pc_plus1,
  input  logic                           i_wb_write,
  input  logic [RB-1:0]                  i_wb_reg,
  input  logic [CANT_BITS_REGISTROS-1:0] i_wb_data,
  input  logic                           i_ex_mem_read,
  input  logic [RB-1:0]                  i_ex_rt,
  output logic                           o_stall,
  output logic                           o_branch_taken,
  output logic [CANT_BITS_ADDR-1:0]      o_branch_dir,
  output logic                           o_valid,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_A,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_B,
  output logic [CANT_BITS_EXTENSION-1:0] o_extension_signo_constante,
  output logic [RB-1:0]                  o_reg_rs,
  output logic [RB-1:0]                  o_reg_rt,
  output logic [RB-1:0]                  o_reg_rd,
  output logic [5:0]                     o_opcode,
  output logic [5:0]                     o_funct,
  output logic                           o_mem_read
);

  localparam logic [5:0] c_OP_LW  = 6'b100011;
  localparam logic [5:0] c_OP_BEQ = 6'b000100;
  localparam logic [5:0] c_OP_BNE = 6'b000101;

  logic [CANT_BITS_REGISTROS-1:0] regfile_q [CANT_REGISTROS];

  logic [5:0]                     w_opcode;
  logic [5:0]                     w_funct;
  logic [RB-1:0]                  w_rs;
  logic [RB-1:0]                  w_rt;
  logic [RB-1:0]                  w_rd;
  logic [CANT_BITS_IMMEDIATE-1:0] w_imm;
  logic [CANT_BITS_EXTENSION-1:0] w_ext;
  logic [CANT_BITS_REGISTROS-1:0] w_data_a;
  logic [CANT_BITS_REGISTROS-1:0] w_data_b;
  logic                           w_match;
  logic                           w_capture;

  assign w_opcode = i_instruction[31:26];
  assign w_rs     = i_instruction[21 +: RB];
  assign w_rt     = i_instruction[16 +: RB];
  assign w_rd     = i_instruction[11 +: RB];
  assign w_funct  = i_instruction[5:0];
  assign w_imm    = i_instruction[CANT_BITS_IMMEDIATE-1:0];

  generate
    if (CANT_BITS_EXTENSION > CANT_BITS_IMMEDIATE) begin : g_ext_sign
      assign w_ext = {{(CANT_BITS_EXTENSION-CANT_BITS_IMMEDIATE){w_imm[CANT_BITS_IMMEDIATE-1]}}, w_imm};
    end else begin : g_ext_none
      assign w_ext = w_imm;
    end
  endgenerate

  // Register 0 is never written, so its storage stays at its reset value of 0.
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      for (int i = 0; i < CANT_REGISTROS; i++) regfile_q[i] <= '0;
    end else if (i_enable && i_wb_write && (i_wb_reg != '0)) begin
      regfile_q[i_wb_reg] <= i_wb_data;
    end
  end

  // Write-through: a same-cycle WB write to the read address wins over the stored value.
  always_comb begin
    w_data_a = regfile_q[w_rs];
    if (w_rs == '0)                             w_data_a = '0;
    else if (i_wb_write && (i_wb_reg == w_rs))  w_data_a = i_wb_data;
  end

  always_comb begin
    w_data_b = regfile_q[w_rt];
    if (w_rt == '0)                             w_data_b = '0;
    else if (i_wb_write && (i_wb_reg == w_rt))  w_data_b = i_wb_data;
  end

  assign o_stall = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_ex_rt == w_rs) || (i_ex_rt == w_rt));

  assign w_match = ((w_opcode == c_OP_BEQ) && (w_data_a == w_data_b)) ||
                   ((w_opcode == c_OP_BNE) && (w_data_a != w_data_b));

  assign o_branch_taken = i_valid && !o_stall && w_match;
  assign o_branch_dir   = i_pc_plus1 + w_imm[CANT_BITS_ADDR-1:0];
  assign w_capture      = i_valid && !o_stall;

  logic                           valid_q,    valid_d;
  logic [CANT_BITS_REGISTROS-1:0] data_a_q,   data_a_d;
  logic [CANT_BITS_REGISTROS-1:0] data_b_q,   data_b_d;
  logic [CANT_BITS_EXTENSION-1:0] ext_q,      ext_d;
  logic [RB-1:0]                  rs_q,       rs_d;
  logic [RB-1:0]                  rt_q,       rt_d;
  logic [RB-1:0]                  rd_q,       rd_d;
  logic [5:0]                     opcode_q,   opcode_d;
  logic [5:0]                     funct_q,    funct_d;
  logic                           mem_read_q, mem_read_d;

  always_comb begin
    valid_d    = valid_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    ext_d      = ext_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    mem_read_d = mem_read_q;
    if (i_enable) begin
      valid_d    = w_capture;
      data_a_d   = w_capture ? w_data_a : '0;
      data_b_d   = w_capture ? w_data_b : '0;
      ext_d      = w_capture ? w_ext    : '0;
      rs_d       = w_capture ? w_rs     : '0;
      rt_d       = w_capture ? w_rt     : '0;
      rd_d       = w_capture ? w_rd     : '0;
      opcode_d   = w_capture ? w_opcode : '0;
      funct_d    = w_capture ? w_funct  : '0;
      mem_read_d = w_capture && (w_opcode == c_OP_LW);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      valid_q    <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      ext_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      funct_q    <= '0;
      mem_read_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      ext_q      <= ext_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      mem_read_q <= mem_read_d;
    end
  end

  assign o_valid                     = valid_q;
  assign o_data_A                    = data_a_q;
  assign o_data_B                    = data_b_q;
  assign o_extension_signo_constante = ext_q;
  assign o_reg_rs                    = rs_q;
  assign o_reg_rt                    = rt_q;
  assign o_reg_rd                    = rd_q;
  assign o_opcode                    = opcode_q;
  assign o_funct                     = funct_q;
  assign o_mem_read                  = mem_read_q;

endmodule
`default_nettype wire
